line_clear_ctrl: RTL and testbench

- Sequencing controller for the 20x10 board cell map (4-bit colour code per cell, 0 = empty).
- After each piece lock it scans the board bottom-up, removes every full row by shifting all rows above it down one row, and clears the top row.
- It accumulates lines-cleared and score totals and raises a busy flag so the spawn/drop logic holds off while the map is being rewritten.
- It accesses the map only through one row read port and one row write port; the map owner performs the actual storage.

---
 rtl/line_clear_if.sv | 21 ++
 rtl/line_clear_ctrl.sv | 93 +++++++++
 tb/tb_line_clear_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/line_clear_if.sv
// line_clear_if: map row ports, start/busy handshake and score outputs of the line-clear controller.
interface line_clear_if #(parameter int COLS = 10, parameter int CW = 4);
  logic                 start;
  logic [4:0]           map_rd_row;
  logic [COLS*CW-1:0]   map_rd_data;
  logic                 map_wr_en;
  logic [4:0]           map_wr_row;
  logic [COLS*CW-1:0]   map_wr_data;
  logic                 busy;
  logic                 clear_done;
  logic [2:0]           lines_pass;
  logic [15:0]          lines_total;
  logic [15:0]          score;
  logic                 top_out;
  modport master (input start, map_rd_data,
                  output map_rd_row, map_wr_en, map_wr_row, map_wr_data,
                         busy, clear_done, lines_pass, lines_total, score, top_out);
  modport slave  (output start, map_rd_data,
                  input map_rd_row, map_wr_en, map_wr_row, map_wr_data,
                        busy, clear_done, lines_pass, lines_total, score, top_out);
endinterface

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: bottom-up full-row scan, shift-down removal and score accumulation for the board map.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 4,
  parameter int PTS1 = 40,
  parameter int PTS2 = 100,
  parameter int PTS3 = 300,
  parameter int PTS4 = 1200
) (
  input logic Clk,
  input logic Reset,
  line_clear_if.master bus
);
  typedef enum logic [2:0] {IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE} state_t;
  state_t state, state_n;
  logic [4:0] r, r_n, s, s_n, rd_hold;
  logic [2:0] cnt, cnt_n;
  logic full;
  logic [15:0] pts;
  logic [16:0] tot_sum, score_sum;
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) full = full & (|bus.map_rd_data[c*CW +: CW]);
  end
  assign pts = cnt == 3'd0 ? 16'd0 : cnt == 3'd1 ? 16'(PTS1) : cnt == 3'd2 ? 16'(PTS2) :
               cnt == 3'd3 ? 16'(PTS3) : 16'(PTS4);
  assign tot_sum   = {1'b0, bus.lines_total} + 17'(cnt);
  assign score_sum = {1'b0, bus.score} + {1'b0, pts};
  always_comb begin
    state_n = state;
    r_n = r;
    s_n = s;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.start) begin
        r_n = 5'(ROWS - 1);
        cnt_n = 3'd0;
        state_n = SCAN_RD;
      end
      SCAN_RD: state_n = SCAN_CHK;
      SCAN_CHK: if (full) begin
        cnt_n = cnt == 3'd7 ? cnt : cnt + 3'd1;
        s_n = r;
        state_n = r == 5'd0 ? CLEAR_TOP : SHIFT_RD;
      end else if (r == 5'd0) state_n = DONE;
      else begin
        r_n = r - 5'd1;
        state_n = SCAN_RD;
      end
      SHIFT_RD: state_n = SHIFT_WR;
      SHIFT_WR: begin
        s_n = s - 5'd1;
        state_n = s == 5'd1 ? CLEAR_TOP : SHIFT_RD;
      end
      CLEAR_TOP: state_n = SCAN_RD;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.busy        = state != IDLE;
  assign bus.clear_done  = state == DONE;
  assign bus.map_wr_en   = state == SHIFT_WR || state == CLEAR_TOP;
  assign bus.map_wr_row  = state == SHIFT_WR ? s : 5'd0;
  assign bus.map_wr_data = state == SHIFT_WR ? bus.map_rd_data : '0;
  // Read address is held between reads so the map sees a stable index.
  assign bus.map_rd_row  = state == SCAN_RD ? r : state == SHIFT_RD ? s - 5'd1 : rd_hold;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      r <= '0;
      s <= '0;
      cnt <= '0;
      rd_hold <= '0;
      bus.top_out <= 1'b0;
      bus.lines_pass <= '0;
      bus.lines_total <= '0;
      bus.score <= '0;
    end else begin
      state <= state_n;
      r <= r_n;
      s <= s_n;
      cnt <= cnt_n;
      rd_hold <= bus.map_rd_row;
      if (state == SCAN_CHK && !full && r == 5'd0 && |bus.map_rd_data) bus.top_out <= 1'b1;
      if (state == DONE) begin
        bus.lines_pass <= cnt;
        bus.lines_total <= tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
        bus.score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
    end
  end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: scoreboard bench with a registered map model; monitor checks each pass on clear_done.
module tb_line_clear_ctrl;
  localparam int ROWS = 20;
  localparam int W = 40;
  localparam logic [W-1:0] FULL = {10{4'h5}};
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic load = 1'b0;
  logic [W-1:0] mem [ROWS];
  logic [W-1:0] init [ROWS];
  logic [W-1:0] emap [ROWS];
  int errors = 0;
  int checks = 0;
  typedef struct {int lp; int lt; int sc; int to; int bc; int wc;} exp_t;
  exp_t q[$];
  line_clear_if bus();
  line_clear_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    if (load) for (int i = 0; i < ROWS; i++) mem[i] <= init[i];
    else if (bus.map_wr_en) mem[bus.map_wr_row] <= bus.map_wr_data;
    bus.map_rd_data <= mem[bus.map_rd_row];
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic load_map();
    @(negedge Clk) load = 1'b1;
    @(negedge Clk) load = 1'b0;
  endtask
  task automatic set_rows(input logic [W-1:0] r19, r18, r17, r16, r0);
    for (int i = 0; i < ROWS; i++) init[i] = '0;
    init[19] = r19; init[18] = r18; init[17] = r17; init[16] = r16; init[0] = r0;
    load_map();
  endtask
  task automatic check_map();
    int bad = 0;
    for (int i = 0; i < ROWS; i++) if (mem[i] !== emap[i]) bad++;
    chk("map_rows_wrong", bad, 0);
  endtask
  task automatic run_pass(input int lp, lt, sc, to, bc, wc, input bit dbl);
    int n = 0;
    exp_t e;
    e.lp = lp; e.lt = lt; e.sc = sc; e.to = to; e.bc = bc; e.wc = wc;
    q.push_back(e);
    @(negedge Clk) bus.start = 1'b1;
    @(negedge Clk) bus.start = 1'b0;
    if (dbl) begin
      repeat (10) @(negedge Clk);
      bus.start = 1'b1;
      @(negedge Clk) bus.start = 1'b0;
    end
    while (bus.busy && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    if (bus.busy) begin
      $display("FAIL pass_timeout: busy still %0d after %0d cycles", bus.busy, n);
      errors++;
      $fatal(1, "pass did not complete");
    end
    repeat (3) @(negedge Clk);
  endtask
  // Monitor: counts busy cycles and writes of the current pass, checks them and the totals on clear_done.
  initial begin
    int bc = 0, wc = 0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        bc = 0;
        wc = 0;
      end else begin
        if (bus.busy) bc++;
        if (bus.map_wr_en) wc++;
        if (bus.clear_done) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: clear_done seen with %0d pending passes", q.size());
          end else begin
            e = q.pop_front();
            chk("busy_cycles", bc, e.bc);
            chk("write_count", wc, e.wc);
            @(negedge Clk);
            chk("lines_pass", int'(bus.lines_pass), e.lp);
            chk("lines_total", int'(bus.lines_total), e.lt);
            chk("score", int'(bus.score), e.sc);
            chk("top_out", int'(bus.top_out), e.to);
          end
          bc = 0;
          wc = 0;
        end
      end
    end
  end
  initial begin
    int n;
    bus.start = 1'b0;
    for (int i = 0; i < ROWS; i++) init[i] = '0;
    load = 1'b1;
    repeat (3) @(negedge Clk);
    load = 1'b0;
    Reset = 1'b0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_en", int'(bus.map_wr_en), 0);
    chk("rst_rd_row", int'(bus.map_rd_row), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_flags", int'({bus.clear_done, bus.top_out, bus.lines_pass}), 0);
    run_pass(0, 0, 0, 0, 41, 0, 0);
    set_rows(FULL, 40'h1, '0, '0, '0);
    run_pass(1, 1, 40, 0, 82, 20, 0);
    for (int i = 0; i < ROWS; i++) emap[i] = '0;
    emap[19] = 40'h1;
    check_map();
    set_rows(FULL, FULL, FULL, FULL, '0);
    run_pass(4, 5, 1240, 0, 205, 80, 0);
    emap[19] = '0;
    check_map();
    set_rows(FULL, 40'h1, FULL, '0, '0);
    run_pass(2, 7, 1340, 0, 121, 39, 0);
    emap[19] = 40'h1;
    check_map();
    set_rows('0, '0, '0, '0, 40'h3000);
    run_pass(0, 7, 1340, 1, 41, 0, 0);
    set_rows('0, '0, '0, '0, '0);
    run_pass(0, 7, 1340, 1, 41, 0, 0);
    // Abort a pass mid shift with Reset, start asserted alongside.
    set_rows(FULL, '0, '0, '0, '0);
    @(negedge Clk) bus.start = 1'b1;
    @(negedge Clk) bus.start = 1'b0;
    n = 0;
    while (!bus.map_wr_en && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("abort_reached_write", int'(bus.map_wr_en), 1);
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    bus.start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.map_wr_en || bus.busy) n++;
      @(negedge Clk);
    end
    chk("abort_activity", n, 0);
    chk("abort_score", int'(bus.score), 0);
    chk("abort_total", int'(bus.lines_total), 0);
    chk("abort_top_out", int'(bus.top_out), 0);
    chk("abort_lines_pass", int'(bus.lines_pass), 0);
    for (int k = 1; k <= 55; k++) begin
      set_rows(FULL, FULL, FULL, FULL, '0);
      run_pass(4, 4 * k, (1200 * k > 65535) ? 65535 : 1200 * k, 0, 205, 80, k == 55);
    end
    chk("queue_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
